mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 34 +++
 rtl/mem_access_unit_load_extract.sv | 29 ++
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the load/store unit: access-flag bit positions, FSM encoding, defaults.
package mem_access_unit_pkg;

  localparam int unsigned XlenDefault          = 32;
  localparam int unsigned XregAddrWidthDefault = 5;

  // Bit positions in the one-hot load flag {LHU,LBU,LW,LH,LB}
  localparam int unsigned LbBit  = 0;
  localparam int unsigned LhBit  = 1;
  localparam int unsigned LwBit  = 2;
  localparam int unsigned LbuBit = 3;
  localparam int unsigned LhuBit = 4;

  // Bit positions in the one-hot store flag {SW,SH,SB}
  localparam int unsigned SbBit = 0;
  localparam int unsigned ShBit = 1;
  localparam int unsigned SwBit = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StReq   = 2'b01,
    StWaitR = 2'b10
  } mau_state_e;

  // A conflicting load+store request is routed down the same error path as a misalignment.
  function automatic logic is_misaligned(input logic [4:0] ld, input logic [2:0] st,
                                         input logic [1:0] off);
    logic half, word;
    half = ld[LhBit] | ld[LhuBit] | st[ShBit];
    word = ld[LwBit] | st[SwBit];
    return ((|ld) & (|st)) | (half & off[0]) | (word & (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extract
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [4:0]      load_flag,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = rdata[{offset[1], 4'b0000} +: 16];
    data     = rdata;
    unique case (1'b1)
      load_flag[LbBit]:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      load_flag[LbuBit]: data = {{(XLEN-8){1'b0}}, byte_sel};
      load_flag[LhBit]:  data = {{(XLEN-16){half_sel[15]}}, half_sel};
      load_flag[LhuBit]: data = {{(XLEN-16){1'b0}}, half_sel};
      default:           data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: passes ALU results to writeback, or runs one load/store over a
// req/gnt/rvalid data-memory port with lane steering, extension and misalignment trapping.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned XLEN           = XlenDefault,
  parameter int unsigned XREG_ADDRWIDTH = XregAddrWidthDefault
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid_in,
  output logic                      ex_ready_out,
  input  logic [XLEN-1:0]           ex_result_in,
  input  logic                      rd_en_in,
  input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
  input  logic [4:0]                load_flag_in,
  input  logic [2:0]                store_flag_in,
  input  logic [XLEN-1:0]           store_data_in,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [XLEN-1:0]           dmem_wdata,
  output logic [3:0]                dmem_wstrb,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic                      wb_valid,
  output logic                      wb_en,
  output logic [XREG_ADDRWIDTH-1:0] wb_addr,
  output logic [XLEN-1:0]           wb_data,
  output logic                      misalign_err
);

  mau_state_e state_q, state_d;

  logic [XLEN-1:0]           addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic [1:0]                off_q, off_d;
  logic [4:0]                ld_q, ld_d;
  logic                      we_q, we_d, rd_en_q, rd_en_d;
  logic [XREG_ADDRWIDTH-1:0] rd_addr_q, rd_addr_d, wb_addr_q, wb_addr_d;
  logic                      wb_valid_q, wb_valid_d, wb_en_q, wb_en_d, mis_q, mis_d;

  logic            accept, is_mem, bad;
  logic [XLEN-1:0] lane_wdata, ld_data;
  logic [3:0]      lane_wstrb;

  assign accept = ex_valid_in & ex_ready_out;
  assign is_mem = (|load_flag_in) | (|store_flag_in);
  assign bad    = is_misaligned(load_flag_in, store_flag_in, ex_result_in[1:0]);

  load_extract #(
    .XLEN(XLEN)
  ) u_load_extract (
    .rdata    (dmem_rdata),
    .offset   (off_q),
    .load_flag(ld_q),
    .data     (ld_data)
  );

  // Store data is replicated across lanes; the strobe picks the lane actually written.
  always_comb begin
    lane_wdata = store_data_in;
    lane_wstrb = 4'b1111;
    if (store_flag_in[SbBit]) begin
      lane_wdata = {(XLEN/8){store_data_in[7:0]}};
      lane_wstrb = 4'b0001 << ex_result_in[1:0];
    end else if (store_flag_in[ShBit]) begin
      lane_wdata = {(XLEN/16){store_data_in[15:0]}};
      lane_wstrb = ex_result_in[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && is_mem && !bad) state_d = StReq;
      StReq:   if (dmem_gnt) state_d = (we_q || dmem_rvalid) ? StIdle : StWaitR;
      StWaitR: if (dmem_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ex_ready_out = (state_q == StIdle);
    dmem_req     = (state_q == StReq);
    dmem_we      = (state_q == StReq) & we_q;
  end

  always_comb begin
    addr_d     = addr_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    ld_d       = ld_q;
    we_d       = we_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    wb_en_d    = 1'b0;
    mis_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!is_mem || bad) begin
            wb_valid_d = 1'b1;
            wb_en_d    = !is_mem & rd_en_in;
            mis_d      = is_mem;
            wb_addr_d  = rd_addr_in;
            wb_data_d  = ex_result_in;
          end else begin
            addr_d    = {ex_result_in[XLEN-1:2], 2'b00};
            off_d     = ex_result_in[1:0];
            wdata_d   = lane_wdata;
            wstrb_d   = lane_wstrb;
            ld_d      = load_flag_in;
            we_d      = |store_flag_in;
            rd_en_d   = rd_en_in;
            rd_addr_d = rd_addr_in;
          end
        end
      end
      StReq: begin
        if (dmem_gnt && (we_q || dmem_rvalid)) begin
          wb_valid_d = 1'b1;
          if (!we_q) begin
            wb_en_d   = rd_en_q;
            wb_addr_d = rd_addr_q;
            wb_data_d = ld_data;
          end
        end
      end
      StWaitR: begin
        if (dmem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_en_d    = rd_en_q;
          wb_addr_d  = rd_addr_q;
          wb_data_d  = ld_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      ld_q       <= '0;
      we_q       <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      ld_q       <= ld_d;
      we_q       <= we_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      wb_en_q    <= wb_en_d;
      mis_q      <= mis_d;
    end
  end

  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_wstrb   = wstrb_q;
  assign wb_valid     = wb_valid_q;
  assign wb_en        = wb_en_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_in, ex_ready_out, rd_en_in;
  logic [31:0] ex_result_in, store_data_in;
  logic [4:0]  rd_addr_in, load_flag_in;
  logic [2:0]  store_flag_in;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_en, misalign_err;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid_in  (ex_valid_in),
    .ex_ready_out (ex_ready_out),
    .ex_result_in (ex_result_in),
    .rd_en_in     (rd_en_in),
    .rd_addr_in   (rd_addr_in),
    .load_flag_in (load_flag_in),
    .store_flag_in(store_flag_in),
    .store_data_in(store_data_in),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .misalign_err (misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] res, input logic [4:0] ld, input logic [2:0] st,
                       input logic [31:0] sdata, input logic [4:0] rd);
    ex_valid_in   = 1'b1;
    ex_result_in  = res;
    load_flag_in  = ld;
    store_flag_in = st;
    store_data_in = sdata;
    rd_en_in      = 1'b1;
    rd_addr_in    = rd;
    step();
    ex_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++;
    if ({ex_ready_out, dmem_req, dmem_we, wb_valid, wb_en, misalign_err} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 100000",
               {ex_ready_out, dmem_req, dmem_we, wb_valid, wb_en, misalign_err});
    end
    n_cmp++;
    if ({dmem_addr, dmem_wdata, wb_data, dmem_wstrb, wb_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h %b %h want all zero",
               dmem_addr, dmem_wdata, wb_data, dmem_wstrb, wb_addr);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    issue(32'h0000_0123, 5'd0, 3'd0, 32'h0, 5'd5);
    n_cmp++;
    if ({wb_valid, wb_en, wb_addr, wb_data} !== {1'b1, 1'b1, 5'd5, 32'h123}) begin
      n_fail++;
      $display("FAIL alu_wb got v%b e%b a%0d d%h want v1 e1 a5 d00000123",
               wb_valid, wb_en, wb_addr, wb_data);
    end
    n_cmp++;
    if ({dmem_req, ex_ready_out} !== 2'b01) begin
      n_fail++;
      $display("FAIL alu_req got req%b rdy%b want req0 rdy1", dmem_req, ex_ready_out);
    end
    issue(32'hCAFE_0001, 5'd0, 3'd0, 32'h0, 5'd0);
    n_cmp++;
    if ({wb_valid, wb_en, wb_addr, wb_data} !== {1'b1, 1'b1, 5'd0, 32'hCAFE_0001}) begin
      n_fail++;
      $display("FAIL alu_x0 got v%b e%b a%0d d%h want v1 e1 a0 dcafe0001",
               wb_valid, wb_en, wb_addr, wb_data);
    end
    step();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_pulse got wb_valid %b want 0", wb_valid);
    end
  endtask

  task automatic test_store_sb();
    int cnt = 0;
    issue(32'h0000_1003, 5'd0, 3'b001, 32'h0000_00AB, 5'd9);
    n_cmp++;
    if ({dmem_we, dmem_addr, dmem_wstrb, dmem_wdata} !== {1'b1, 32'h1000, 4'b1000, 32'hABABABAB})
    begin
      n_fail++;
      $display("FAIL sb_bus got we%b a%h s%b d%h want we1 a00001000 s1000 dabababab",
               dmem_we, dmem_addr, dmem_wstrb, dmem_wdata);
    end
    n_cmp++;
    if (ex_ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_ready got %b want 0", ex_ready_out);
    end
    for (int i = 0; i < 4; i++) begin
      if (dmem_req === 1'b1) cnt++;
      if (i == 3) dmem_gnt = 1'b1;
      step();
    end
    dmem_gnt = 1'b0;
    n_cmp++;
    if (cnt != 4) begin
      n_fail++;
      $display("FAIL sb_req_cycles got %0d want 4", cnt);
    end
    n_cmp++;
    if ({wb_valid, wb_en, dmem_req, ex_ready_out} !== 4'b1001) begin
      n_fail++;
      $display("FAIL sb_done got v%b e%b req%b rdy%b want v1 e0 req0 rdy1",
               wb_valid, wb_en, dmem_req, ex_ready_out);
    end
    step();
  endtask

  task automatic test_store_sh();
    issue(32'h0000_1002, 5'd0, 3'b010, 32'h1234_ABCD, 5'd1);
    n_cmp++;
    if ({dmem_req, dmem_addr, dmem_wstrb, dmem_wdata} !== {1'b1, 32'h1000, 4'b1100, 32'hABCDABCD})
    begin
      n_fail++;
      $display("FAIL sh_bus got req%b a%h s%b d%h want req1 a00001000 s1100 dabcdabcd",
               dmem_req, dmem_addr, dmem_wstrb, dmem_wdata);
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    n_cmp++;
    if ({wb_valid, wb_en, ex_ready_out} !== 3'b101) begin
      n_fail++;
      $display("FAIL sh_done got v%b e%b rdy%b want 101", wb_valid, wb_en, ex_ready_out);
    end
    step();
  endtask

  task automatic test_loads();
    logic [4:0]  ld_tab[5] = '{5'b00001, 5'b01000, 5'b00010, 5'b10000, 5'b00100};
    logic [31:0] ad_tab[5] = '{32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h2000};
    logic [31:0] rd_tab[5] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000, 32'h8001_0000,
                               32'hDEAD_BEEF};
    logic [31:0] ex_tab[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                               32'hDEAD_BEEF};
    logic        same[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(ad_tab[i], ld_tab[i], 3'd0, 32'h0, 5'(10 + i));
      n_cmp++;
      if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, ad_tab[i] & 32'hFFFF_FFFC}) begin
        n_fail++;
        $display("FAIL load%0d_req got req%b we%b a%h", i, dmem_req, dmem_we, dmem_addr);
      end
      dmem_gnt    = 1'b1;
      dmem_rvalid = same[i];
      dmem_rdata  = rd_tab[i];
      step();
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (!same[i]) begin
        n_cmp++;
        if ({dmem_req, wb_valid, ex_ready_out} !== 3'b000) begin
          n_fail++;
          $display("FAIL load%0d_wait got req%b v%b rdy%b want 000", i, dmem_req, wb_valid,
                   ex_ready_out);
        end
        dmem_rvalid = 1'b1;
        step();
        dmem_rvalid = 1'b0;
      end
      n_cmp++;
      if ({wb_valid, wb_en, wb_addr, wb_data} !== {1'b1, 1'b1, 5'(10 + i), ex_tab[i]}) begin
        n_fail++;
        $display("FAIL load%0d_wb got v%b e%b a%0d d%h want v1 e1 a%0d d%h", i, wb_valid, wb_en,
                 wb_addr, wb_data, 10 + i, ex_tab[i]);
      end
      dmem_rdata = 32'h0;
      step();
    end
  endtask

  task automatic test_misalign();
    logic [31:0] ad_tab[3] = '{32'h2002, 32'h1001, 32'h1000};
    logic [4:0]  ld_tab[3] = '{5'b00100, 5'b00000, 5'b00001};
    logic [2:0]  st_tab[3] = '{3'b000, 3'b010, 3'b001};
    for (int i = 0; i < 3; i++) begin
      issue(ad_tab[i], ld_tab[i], st_tab[i], 32'h55, 5'd3);
      n_cmp++;
      if ({misalign_err, wb_valid, wb_en, dmem_req, ex_ready_out} !== 5'b11001) begin
        n_fail++;
        $display("FAIL mis%0d got err%b v%b e%b req%b rdy%b want 11001", i, misalign_err,
                 wb_valid, wb_en, dmem_req, ex_ready_out);
      end
      step();
      n_cmp++;
      if ({misalign_err, wb_valid, dmem_req} !== 3'b000) begin
        n_fail++;
        $display("FAIL mis%0d_after got err%b v%b req%b want 000", i, misalign_err, wb_valid,
                 dmem_req);
      end
    end
  endtask

  task automatic test_spurious();
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    step();
    step();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    n_cmp++;
    if ({wb_valid, dmem_req, ex_ready_out} !== 3'b001) begin
      n_fail++;
      $display("FAIL spurious got v%b req%b rdy%b want 001", wb_valid, dmem_req, ex_ready_out);
    end
  endtask

  task automatic test_reset_mid();
    issue(32'h0000_3000, 5'b00100, 3'd0, 32'h0, 5'd7);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ex_ready_out, dmem_req, wb_valid, wb_en, misalign_err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL rstmid_ctrl got rdy%b req%b v%b e%b err%b want 10000", ex_ready_out,
               dmem_req, wb_valid, wb_en, misalign_err);
    end
    n_cmp++;
    if ({dmem_addr, dmem_wdata, wb_data, dmem_wstrb, wb_addr} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_data got %h %h %h %b %h want all zero", dmem_addr, dmem_wdata,
               wb_data, dmem_wstrb, wb_addr);
    end
    rst_n = 1'b1;
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    step();
    dmem_rvalid = 1'b0;
    step();
    n_cmp++;
    if ({wb_valid, wb_data, ex_ready_out} !== {1'b0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_late got v%b d%h rdy%b want v0 d0 rdy1", wb_valid, wb_data,
               ex_ready_out);
    end
  endtask

  task automatic test_back_to_back();
    ex_valid_in   = 1'b1;
    ex_result_in  = 32'h0000_4000;
    load_flag_in  = 5'd0;
    store_flag_in = 3'b100;
    store_data_in = 32'h0000_0055;
    rd_en_in      = 1'b1;
    rd_addr_in    = 5'd2;
    step();
    store_flag_in = 3'd0;
    ex_result_in  = 32'h0000_0077;
    store_data_in = 32'h0000_0099;
    rd_addr_in    = 5'd7;
    n_cmp++;
    if ({ex_ready_out, dmem_wdata, dmem_wstrb} !== {1'b0, 32'h55, 4'b1111}) begin
      n_fail++;
      $display("FAIL b2b_req got rdy%b d%h s%b want rdy0 d00000055 s1111", ex_ready_out,
               dmem_wdata, dmem_wstrb);
    end
    step();
    n_cmp++;
    if ({ex_ready_out, wb_valid, dmem_req} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_hold got rdy%b v%b req%b want 001", ex_ready_out, wb_valid, dmem_req);
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    n_cmp++;
    if ({wb_valid, wb_en, ex_ready_out} !== 3'b101) begin
      n_fail++;
      $display("FAIL b2b_store got v%b e%b rdy%b want 101", wb_valid, wb_en, ex_ready_out);
    end
    step();
    ex_valid_in = 1'b0;
    n_cmp++;
    if ({wb_valid, wb_en, wb_addr, wb_data} !== {1'b1, 1'b1, 5'd7, 32'h77}) begin
      n_fail++;
      $display("FAIL b2b_alu got v%b e%b a%0d d%h want v1 e1 a7 d00000077", wb_valid, wb_en,
               wb_addr, wb_data);
    end
    step();
    n_cmp++;
    if ({wb_valid, dmem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_end got v%b req%b want 00", wb_valid, dmem_req);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    ex_valid_in   = 1'b0;
    ex_result_in  = '0;
    rd_en_in      = 1'b0;
    rd_addr_in    = '0;
    load_flag_in  = '0;
    store_flag_in = '0;
    store_data_in = '0;
    dmem_gnt      = 1'b0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = '0;
    test_reset();
    test_alu();
    test_store_sb();
    test_store_sh();
    test_loads();
    test_misalign();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
